// File: rtl/fb_region_reader.sv
// Frame-buffer region reader: walks a screen-clipped rectangle in raster order,
// issues one-cycle-latency reads and streams pixels through a 2-entry valid/ready FIFO.
module fb_region_reader #(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    input  logic [7:0]  w,
    input  logic [6:0]  h,
    output logic        rd_en,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [2:0]  pix_colour,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);
    localparam logic [8:0]  SCR_W9  = 9'(SCR_W);
    localparam logic [7:0]  SCR_H8  = 8'(SCR_H);
    localparam logic [14:0] SCR_W15 = 15'(SCR_W);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t          state_q, state_d;
    logic [7:0]      x_q, x_d, xs_q, xs_d;
    logic [6:0]      y_q, y_d;
    logic [8:0]      xe_q, xe_d;
    logic [7:0]      ye_q, ye_d;
    logic [14:0]     addr_q, addr_d, row_q, row_d;
    logic            rdv_q, rdv_d, rlast_q, rlast_d;
    logic [7:0]      rx_q, rx_d;
    logic [6:0]      ry_q, ry_d;
    logic [1:0][2:0] fcol_q, fcol_d;
    logic [1:0][7:0] fx_q, fx_d;
    logic [1:0][6:0] fy_q, fy_d;
    logic [1:0]      flast_q, flast_d;
    logic            wp_q, wp_d, rp_q, rp_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic [8:0] x_sum, x_clip;
    logic [7:0] y_sum, y_clip;
    logic [2:0] committed;
    logic       empty, push, pop, issue, x_at_end, y_at_end;

    always_comb begin
        x_sum  = {1'b0, x0} + {1'b0, w};
        y_sum  = {1'b0, y0} + {1'b0, h};
        x_clip = (x_sum > SCR_W9) ? SCR_W9 : x_sum;
        y_clip = (y_sum > SCR_H8) ? SCR_H8 : y_sum;
        empty  = (w == 8'd0) || (h == 7'd0) || ({1'b0, x0} >= SCR_W9) || ({1'b0, y0} >= SCR_H8);

        push = rdv_q;
        pop  = (cnt_q != 2'd0) && pix_ready;
        // Entries that will still occupy the FIFO next cycle; a pop this cycle frees
        // its slot in time for a read issued now, which keeps 1 pixel/cycle.
        committed = {1'b0, cnt_q} + {2'b0, rdv_q} - {2'b0, pop};
        issue     = (state_q == READ) && (committed < 3'd2);
        x_at_end  = ({1'b0, x_q} + 9'd1) == xe_q;
        y_at_end  = ({1'b0, y_q} + 8'd1) == ye_q;

        state_d = state_q;
        x_d = x_q;  xs_d = xs_q;  y_d = y_q;  xe_d = xe_q;  ye_d = ye_q;
        addr_d = addr_q;  row_d = row_q;
        rdv_d = issue;  rlast_d = rlast_q;  rx_d = rx_q;  ry_d = ry_q;
        fcol_d = fcol_q;  fx_d = fx_q;  fy_d = fy_q;  flast_d = flast_q;
        wp_d = wp_q;  rp_d = rp_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        busy_d = busy_q;  done_d = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                        x_d     = x0;
                        xs_d    = x0;
                        y_d     = y0;
                        xe_d    = x_clip;
                        ye_d    = y_clip;
                        addr_d  = 15'(y0) * SCR_W15 + 15'(x0);
                        row_d   = 15'(y0) * SCR_W15 + 15'(x0);
                    end
                end
            end
            READ: begin
                if (issue) begin
                    if (x_at_end && y_at_end) begin
                        state_d = DRAIN;
                    end else if (x_at_end) begin
                        x_d    = xs_q;
                        y_d    = y_q + 7'd1;
                        row_d  = row_q + SCR_W15;
                        addr_d = row_q + SCR_W15;
                    end else begin
                        x_d    = x_q + 8'd1;
                        addr_d = addr_q + 15'd1;
                    end
                end
            end
            DRAIN: begin
                if (pop && flast_q[rp_q]) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Coordinates travel alongside the read so they meet rd_data one cycle later.
        if (issue) begin
            rx_d    = x_q;
            ry_d    = y_q;
            rlast_d = x_at_end && y_at_end;
        end
        if (push) begin
            fcol_d[wp_q]  = rd_data;
            fx_d[wp_q]    = rx_q;
            fy_d[wp_q]    = ry_q;
            flast_d[wp_q] = rlast_q;
            wp_d          = ~wp_q;
        end
        if (pop) begin
            rp_d = ~rp_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;  xs_q <= '0;  y_q <= '0;  xe_q <= '0;  ye_q <= '0;
            addr_q  <= '0;  row_q <= '0;
            rdv_q   <= 1'b0;  rlast_q <= 1'b0;  rx_q <= '0;  ry_q <= '0;
            fcol_q  <= '0;  fx_q <= '0;  fy_q <= '0;  flast_q <= '0;
            wp_q    <= 1'b0;  rp_q <= 1'b0;  cnt_q <= '0;
            busy_q  <= 1'b0;  done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;  xs_q <= xs_d;  y_q <= y_d;  xe_q <= xe_d;  ye_q <= ye_d;
            addr_q  <= addr_d;  row_q <= row_d;
            rdv_q   <= rdv_d;  rlast_q <= rlast_d;  rx_q <= rx_d;  ry_q <= ry_d;
            fcol_q  <= fcol_d;  fx_q <= fx_d;  fy_q <= fy_d;  flast_q <= flast_d;
            wp_q    <= wp_d;  rp_q <= rp_d;  cnt_q <= cnt_d;
            busy_q  <= busy_d;  done_q <= done_d;
        end
    end

    assign rd_en      = issue;
    assign rd_addr    = addr_q;
    assign pix_valid  = (cnt_q != 2'd0);
    assign pix_colour = fcol_q[rp_q];
    assign pix_x      = fx_q[rp_q];
    assign pix_y      = fy_q[rp_q];
    assign pix_last   = flast_q[rp_q];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
